// File: rtl/ddr_tx_serializer.sv
// Parallel-to-DDR serializer feeding an ODDR (SAME_EDGE): two bits per clock on d1/d2, all outputs registered.
// Optional build macro DDR_TX_SERIALIZER_LSB_FIRST_EN selects LSB-first pair order (default MSB first).
module ddr_tx_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             d1,
  output logic             d2,
  output logic             frame
);

  localparam int BEATS = WIDTH / 2;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             d1_q, d1_d;
  logic             d2_q, d2_d;
  logic             frame_q, frame_d;
  logic             accept;

  // Next pair to drive, packed as {d1, d2}.
  function automatic logic [1:0] head_pair(input logic [WIDTH-1:0] w);
`ifdef DDR_TX_SERIALIZER_LSB_FIRST_EN
    return {w[0], w[1]};
`else
    return {w[WIDTH-1], w[WIDTH-2]};
`endif
  endfunction

  function automatic logic [WIDTH-1:0] drop_pair(input logic [WIDTH-1:0] w);
`ifdef DDR_TX_SERIALIZER_LSB_FIRST_EN
    return w >> 2;
`else
    return w << 2;
`endif
  endfunction

  // Ready depends only on state/counter, never on s_valid.
  assign s_ready = !rst && ((state_q == ST_IDLE) || (cnt_q == LAST_BEAT));
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    frame_d = frame_q;
    if (accept) begin
      // First beat goes straight to the output flops; the rest waits in sreg.
      {d1_d, d2_d} = head_pair(s_data);
      sreg_d  = drop_pair(s_data);
      cnt_d   = '0;
      frame_d = 1'b1;
      state_d = ST_SHIFT;
    end else if (state_q == ST_SHIFT && cnt_q != LAST_BEAT) begin
      {d1_d, d2_d} = head_pair(sreg_q);
      sreg_d  = drop_pair(sreg_q);
      cnt_d   = cnt_q + 1'b1;
    end else begin
      d1_d    = IDLE_LEVEL;
      d2_d    = IDLE_LEVEL;
      frame_d = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      d1_q    <= IDLE_LEVEL;
      d2_q    <= IDLE_LEVEL;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      frame_q <= frame_d;
    end
  end

  assign d1    = d1_q;
  assign d2    = d2_q;
  assign frame = frame_q;

endmodule
